// File: rtl/flappy_game_core.sv
// Flappy-bird game-state engine: bird physics, NUM_PIPES scrolling pipes, collision, scoring and game FSM.
// All game state advances only on frame_tick while not paused; the LFSR and flap edge detector run every clk.
module flappy_game_core #(
    parameter int NUM_PIPES     = 2,
    parameter int X_BITS        = 11,
    parameter int Y_BITS        = 9,
    parameter int SCREEN_W      = 640,
    parameter int SCREEN_H      = 480,
    parameter int BIRD_X        = 160,
    parameter int BIRD_W        = 16,
    parameter int BIRD_H        = 16,
    parameter int PIPE_W        = 32,
    parameter int PIPE_SPACING  = 320,
    parameter int PIPE_SPEED    = 2,
    parameter int GAP_H         = 120,
    parameter int GAP_MIN       = 32,
    parameter int GAP_RAND_BITS = 8,
    parameter int GRAVITY       = 1,
    parameter int FLAP_V        = 8,
    parameter int MAX_FALL      = 10,
    parameter int SCORE_BITS    = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          frame_tick,
    input  logic                          flap,
    input  logic                          pause,
    output logic [Y_BITS-1:0]             bird_y,
    output logic [NUM_PIPES*X_BITS-1:0]   pipe_x,
    output logic [NUM_PIPES*Y_BITS-1:0]   pipe_gap_y,
    output logic [SCORE_BITS-1:0]         score,
    output logic [1:0]                    state,
    output logic                          collide
);
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_PLAY = 2'd1, S_OVER = 2'd2} state_e;

    localparam logic [Y_BITS-1:0]          Y_START = Y_BITS'((SCREEN_H - BIRD_H) / 2);
    localparam logic signed [Y_BITS+1:0]   Y_FLOOR = (Y_BITS+2)'(SCREEN_H - BIRD_H);
    localparam logic signed [Y_BITS:0]     V_FLAP  = (Y_BITS+1)'(-FLAP_V);
    localparam logic signed [Y_BITS:0]     V_GRAV  = (Y_BITS+1)'(GRAVITY);
    localparam logic signed [Y_BITS:0]     V_MAX   = (Y_BITS+1)'(MAX_FALL);
    localparam logic [X_BITS-1:0]          X_SPEED = X_BITS'(PIPE_SPEED);
    localparam logic [X_BITS-1:0]          X_WRAP  = X_BITS'(NUM_PIPES*PIPE_SPACING - PIPE_SPEED);
    localparam logic [X_BITS:0]            X_PW    = (X_BITS+1)'(PIPE_W);
    localparam logic [X_BITS:0]            X_BL    = (X_BITS+1)'(BIRD_X);
    localparam logic [X_BITS:0]            X_BR    = (X_BITS+1)'(BIRD_X + BIRD_W);
    localparam logic [Y_BITS:0]            Y_BH    = (Y_BITS+1)'(BIRD_H);
    localparam logic [Y_BITS:0]            Y_GH    = (Y_BITS+1)'(GAP_H);
    localparam logic [Y_BITS-1:0]          G_MIN   = Y_BITS'(GAP_MIN);
    localparam logic [Y_BITS-1:0]          G_RST   = Y_BITS'(GAP_MIN + 64);

    state_e                               state_q;
    logic [Y_BITS-1:0]                    bird_y_q, bird_y_d;
    logic signed [Y_BITS:0]               vel_q, vel_g, vel_d;
    logic signed [Y_BITS+1:0]             y_sum;
    logic [NUM_PIPES-1:0][X_BITS-1:0]     pipe_x_q, pipe_x_d;
    logic [NUM_PIPES-1:0][Y_BITS-1:0]     gap_q, gap_d;
    logic [NUM_PIPES-1:0]                 hit, pass;
    logic [SCORE_BITS-1:0]                score_q, score_d;
    logic [SCORE_BITS:0]                  sc_sum;
    logic [2:0]                           n_pass;
    logic [15:0]                          lfsr_q;
    logic                                 collide_q, flap_prev_q, flap_req_q;
    logic                                 floor_hit, tick_ok, flap_rise, lfsr_fb;

    assign tick_ok   = frame_tick & ~pause;
    assign flap_rise = flap & ~flap_prev_q;
    assign lfsr_fb   = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];

    always_comb begin
        vel_g     = vel_q + V_GRAV;
        vel_d     = flap_req_q ? V_FLAP : ((vel_g > V_MAX) ? V_MAX : vel_g);
        y_sum     = $signed({2'b00, bird_y_q}) + $signed({vel_d[Y_BITS], vel_d});
        floor_hit = 1'b0;
        bird_y_d  = y_sum[Y_BITS-1:0];
        // Hitting the ceiling just pins the bird; only the floor ends the game.
        if (y_sum[Y_BITS+1]) begin
            bird_y_d = '0;
        end else if (y_sum >= Y_FLOOR) begin
            bird_y_d  = Y_FLOOR[Y_BITS-1:0];
            floor_hit = 1'b1;
        end
    end

    for (genvar g = 0; g < NUM_PIPES; g++) begin : g_pipe
        logic [X_BITS:0] x_r_old, x_r_new;
        logic            h_ov, in_gap, wrap;
        assign wrap          = pipe_x_q[g] < X_SPEED;
        assign x_r_old       = {1'b0, pipe_x_q[g]} + X_PW;
        assign x_r_new       = {1'b0, pipe_x_d[g]} + X_PW;
        assign h_ov          = ({1'b0, pipe_x_q[g]} < X_BR) && (x_r_old > X_BL);
        assign in_gap        = (bird_y_q >= gap_q[g]) &&
                               (({1'b0, bird_y_q} + Y_BH) <= ({1'b0, gap_q[g]} + Y_GH));
        assign hit[g]        = h_ov & ~in_gap;
        assign pipe_x_d[g]   = wrap ? pipe_x_q[g] + X_WRAP : pipe_x_q[g] - X_SPEED;
        assign gap_d[g]      = wrap ? G_MIN + Y_BITS'(lfsr_q[GAP_RAND_BITS-1:0]) : gap_q[g];
        assign pass[g]       = (x_r_old >= X_BL) && (x_r_new < X_BL);
    end

    always_comb begin
        n_pass = '0;
        for (int i = 0; i < NUM_PIPES; i++) n_pass = n_pass + {2'b00, pass[i]};
        sc_sum  = {1'b0, score_q} + (SCORE_BITS+1)'(n_pass);
        score_d = sc_sum[SCORE_BITS] ? '1 : sc_sum[SCORE_BITS-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            bird_y_q    <= Y_START;
            vel_q       <= '0;
            score_q     <= '0;
            collide_q   <= 1'b0;
            flap_prev_q <= 1'b0;
            flap_req_q  <= 1'b0;
            lfsr_q      <= 16'hACE1;
            for (int i = 0; i < NUM_PIPES; i++) begin
                pipe_x_q[i] <= X_BITS'(SCREEN_W + i*PIPE_SPACING);
                gap_q[i]    <= G_RST;
            end
        end else begin
            lfsr_q      <= {lfsr_q[14:0], lfsr_fb};
            flap_prev_q <= flap;
            collide_q   <= 1'b0;
            // Any frame_tick consumes a pending flap, so a flap during pause is dropped.
            if (frame_tick)     flap_req_q <= 1'b0;
            else if (flap_rise) flap_req_q <= 1'b1;
            if (tick_ok) begin
                case (state_q)
                    S_IDLE: if (flap_req_q) begin
                        state_q  <= S_PLAY;
                        score_q  <= '0;
                        vel_q    <= vel_d;
                        bird_y_q <= bird_y_d;
                    end
                    S_PLAY: if (|hit) begin
                        state_q   <= S_OVER;
                        collide_q <= 1'b1;
                    end else begin
                        vel_q    <= vel_d;
                        bird_y_q <= bird_y_d;
                        pipe_x_q <= pipe_x_d;
                        gap_q    <= gap_d;
                        score_q  <= score_d;
                        if (floor_hit) begin
                            state_q   <= S_OVER;
                            collide_q <= 1'b1;
                        end
                    end
                    S_OVER: if (flap_req_q) begin
                        state_q  <= S_IDLE;
                        bird_y_q <= Y_START;
                        vel_q    <= '0;
                        for (int i = 0; i < NUM_PIPES; i++) begin
                            pipe_x_q[i] <= X_BITS'(SCREEN_W + i*PIPE_SPACING);
                            gap_q[i]    <= G_RST;
                        end
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign bird_y     = bird_y_q;
    assign pipe_x     = pipe_x_q;
    assign pipe_gap_y = gap_q;
    assign score      = score_q;
    assign state      = state_q;
    assign collide    = collide_q;
endmodule

// File: tb/tb_flappy_game_core.sv
// Scoreboard bench for flappy_game_core: default instance plus a narrow-gap instance for scoring/wrap/pause.
module tb_flappy_game_core;
    localparam int M_BY = 1, M_PX0 = 2, M_PX1 = 4, M_GAP = 8, M_SC = 16, M_ST = 32, M_CO = 64;

    logic clk = 1'b0, rst_n = 1'b0;
    logic ft_a = 1'b0, fl_a = 1'b0, pa_a = 1'b0;
    logic ft_b = 1'b0, fl_b = 1'b0, pa_b = 1'b0;
    logic probe = 1'b0;
    logic [8:0]  a_by, b_by;
    logic [21:0] a_px, b_px;
    logic [17:0] a_gp, b_gp;
    logic [7:0]  a_sc, b_sc;
    logic [1:0]  a_st, b_st;
    logic        a_co, b_co;

    always #5 clk = ~clk;

    flappy_game_core u_dut_a (
        .clk(clk), .rst_n(rst_n), .frame_tick(ft_a), .flap(fl_a), .pause(pa_a),
        .bird_y(a_by), .pipe_x(a_px), .pipe_gap_y(a_gp), .score(a_sc), .state(a_st), .collide(a_co));

    flappy_game_core #(.GAP_MIN(150), .GAP_RAND_BITS(1)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .frame_tick(ft_b), .flap(fl_b), .pause(pa_b),
        .bird_y(b_by), .pipe_x(b_px), .pipe_gap_y(b_gp), .score(b_sc), .state(b_st), .collide(b_co));

    typedef struct {
        string name;
        bit    sel;
        int    mask;
        int    by, px0, px1, glo, ghi, sc, st, co;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0, n_bad = 0;
    int   col_a = 0, col_b = 0;
    event smp;

    function automatic exp_t mk(string nm, bit sel, int mask, int by, int px0, int px1,
                                int glo, int ghi, int sc, int st, int co);
        exp_t e;
        e.name = nm; e.sel = sel; e.mask = mask; e.by = by; e.px0 = px0; e.px1 = px1;
        e.glo = glo; e.ghi = ghi; e.sc = sc; e.st = st; e.co = co;
        return e;
    endfunction

    function automatic void cmp(string nm, string fld, int act, int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s.%s actual=%0d required=%0d", nm, fld, act, req);
        end
    endfunction

    always @(negedge clk) begin
        if (a_co) col_a++;
        if (b_co) col_b++;
    end

    always @(posedge clk) if (ft_a | ft_b | probe) begin #1; ->smp; end

    initial begin : monitor
        exp_t e;
        int by, px0, px1, g0, sc, st, co;
        forever begin
            @smp;
            if (sb.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL sb_underflow actual=empty required=entry");
            end else begin
                e = sb.pop_front();
                if (e.sel) begin
                    by = int'(b_by); px0 = int'(b_px[10:0]); px1 = int'(b_px[21:11]);
                    g0 = int'(b_gp[8:0]); sc = int'(b_sc); st = int'(b_st); co = int'(b_co);
                end else begin
                    by = int'(a_by); px0 = int'(a_px[10:0]); px1 = int'(a_px[21:11]);
                    g0 = int'(a_gp[8:0]); sc = int'(a_sc); st = int'(a_st); co = int'(a_co);
                end
                if ((e.mask & M_BY)  != 0) cmp(e.name, "bird_y", by, e.by);
                if ((e.mask & M_PX0) != 0) cmp(e.name, "pipe_x0", px0, e.px0);
                if ((e.mask & M_PX1) != 0) cmp(e.name, "pipe_x1", px1, e.px1);
                if ((e.mask & M_SC)  != 0) cmp(e.name, "score", sc, e.sc);
                if ((e.mask & M_ST)  != 0) cmp(e.name, "state", st, e.st);
                if ((e.mask & M_CO)  != 0) cmp(e.name, "collide", co, e.co);
                if ((e.mask & M_GAP) != 0) begin
                    n_cmp++;
                    if (g0 < e.glo || g0 > e.ghi) begin
                        n_bad++;
                        $display("FAIL %s.gap_y0 actual=%0d required=%0d..%0d", e.name, g0, e.glo, e.ghi);
                    end
                end
            end
        end
    end

    task automatic tick(input bit sel, input bit fl, input exp_t e);
        if (fl) begin
            if (sel) fl_b = 1'b1; else fl_a = 1'b1;
            @(negedge clk); @(negedge clk);
            fl_a = 1'b0; fl_b = 1'b0;
            @(negedge clk);
        end
        sb.push_back(e);
        if (sel) ft_b = 1'b1; else ft_a = 1'b1;
        @(negedge clk);
        ft_a = 1'b0; ft_b = 1'b0;
        @(negedge clk);
    endtask

    task automatic probe_chk(input exp_t e);
        sb.push_back(e);
        probe = 1'b1;
        @(negedge clk);
        probe = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int m, by, px0, px1, glo, ghi, sc, st, co;
        bit f;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset values on both instances.
        probe_chk(mk("rst_a", 0, M_BY|M_PX0|M_PX1|M_GAP|M_SC|M_ST|M_CO, 232, 640, 960, 96, 96, 0, 0, 0));
        probe_chk(mk("rst_b", 1, M_BY|M_PX0|M_PX1|M_GAP|M_SC|M_ST|M_CO, 232, 640, 960, 214, 214, 0, 0, 0));

        for (int i = 0; i < 3; i++)
            tick(0, 0, mk($sformatf("idle%0d", i), 0, M_BY|M_PX0|M_PX1|M_ST, 232, 640, 960, 0, 0, 0, 0, 0));

        tick(0, 1, mk("start", 0, M_BY|M_PX0|M_SC|M_ST|M_CO, 224, 640, 0, 0, 0, 0, 1, 0));

        // Free fall until the floor.
        for (int k = 1; k <= 40; k++) begin
            m = M_ST|M_CO; by = 0; px0 = 0;
            st = (k < 40) ? 1 : 2;
            co = (k == 40) ? 1 : 0;
            case (k)
                10: begin m = m | M_BY | M_PX0; by = 199; px0 = 620; end
                18: begin m = m | M_BY; by = 251; end
                39: begin m = m | M_BY; by = 461; end
                40: begin m = m | M_BY | M_SC; by = 464; end
                default: ;
            endcase
            tick(0, 0, mk($sformatf("fall%0d", k), 0, m, by, px0, 0, 0, 0, 0, st, co));
        end

        for (int k = 0; k < 10; k++)
            tick(0, 0, mk($sformatf("over%0d", k), 0, M_BY|M_SC|M_ST|M_CO, 464, 0, 0, 0, 0, 0, 2, 0));

        tick(0, 1, mk("restart", 0, M_BY|M_PX0|M_PX1|M_SC|M_ST|M_CO, 232, 640, 960, 0, 0, 0, 0, 0));

        // Drive the bird to y=4, then one more flap pins it at the ceiling.
        tick(0, 1, mk("ceil_start", 0, M_BY|M_ST, 224, 0, 0, 0, 0, 0, 1, 0));
        for (int k = 1; k <= 7; k++)
            tick(0, 0, mk($sformatf("ceil_g%0d", k), 0, (k == 7) ? (M_BY|M_ST|M_CO) : (M_ST|M_CO),
                          196, 0, 0, 0, 0, 0, 1, 0));
        for (int k = 1; k <= 24; k++)
            tick(0, 1, mk($sformatf("ceil_f%0d", k), 0, M_BY|M_ST|M_CO, 196 - 8*k, 0, 0, 0, 0, 0, 1, 0));
        tick(0, 1, mk("ceil_clamp", 0, M_BY|M_ST|M_CO, 0, 0, 0, 0, 0, 0, 1, 0));

        // Narrow-gap instance: flap schedule keeps the bird within [235,271].
        tick(1, 1, mk("b_start", 1, M_BY|M_PX0|M_GAP|M_ST, 224, 640, 0, 214, 214, 0, 1, 0));
        for (int n = 1; n <= 321; n++) begin
            f = (n >= 21) && (((n - 21) % 17) == 0);
            m = M_ST|M_CO; by = 0; px0 = 0; px1 = 0; glo = 0; ghi = 0; sc = 0;
            case (n)
                20:  begin m = m | M_BY; by = 271; end
                256: begin m = m | M_BY | M_PX0 | M_SC; by = 256; px0 = 128; sc = 0; end
                257: begin m = m | M_BY | M_PX0 | M_SC; by = 263; px0 = 126; sc = 1; end
                320: begin m = m | M_BY | M_PX0 | M_SC; by = 238; px0 = 0; sc = 1; end
                321: begin m = m | M_BY | M_PX0 | M_PX1 | M_GAP | M_SC;
                           by = 241; px0 = 638; px1 = 318; glo = 150; ghi = 151; sc = 1; end
                default: ;
            endcase
            tick(1, f, mk($sformatf("b_t%0d", n), 1, m, by, px0, px1, glo, ghi, sc, 1, 0));
        end

        // Flap held across a paused tick must be discarded.
        pa_b = 1'b1; fl_b = 1'b1;
        @(negedge clk); @(negedge clk);
        sb.push_back(mk("b_paused", 1, M_BY|M_PX0|M_SC|M_ST|M_CO, 241, 638, 0, 0, 0, 1, 1, 0));
        ft_b = 1'b1;
        @(negedge clk);
        ft_b = 1'b0;
        @(negedge clk);
        fl_b = 1'b0;
        @(negedge clk);
        pa_b = 1'b0;
        @(negedge clk);
        tick(1, 0, mk("b_after_pause", 1, M_BY|M_PX0|M_SC|M_ST|M_CO, 245, 636, 0, 0, 0, 1, 1, 0));

        // Asynchronous reset while both instances are playing.
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        sb.push_back(mk("midrst_a", 0, M_BY|M_PX0|M_PX1|M_GAP|M_SC|M_ST|M_CO, 232, 640, 960, 96, 96, 0, 0, 0));
        ->smp;
        #1;
        sb.push_back(mk("midrst_b", 1, M_BY|M_PX0|M_PX1|M_GAP|M_SC|M_ST|M_CO, 232, 640, 960, 214, 214, 0, 0, 0));
        ->smp;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        cmp("pulses_a", "collide_cycles", col_a, 1);
        cmp("pulses_b", "collide_cycles", col_b, 0);
        cmp("scoreboard", "leftover", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
